// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention-score engine: FSM state encoding
// and signed saturation to an arbitrary element width.
package attn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Working width for saturation; holds any accumulator up to 64 bits.
  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 32'd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/score_mac.sv
// One-score multiply-accumulate unit: full-precision signed accumulation,
// then arithmetic shift and saturation back to the element width.
module score_mac
  import attn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned E          = 8,
  parameter int unsigned SHIFT      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_score
);

  localparam int unsigned ACC_W = 2 * DATA_WIDTH + $clog2(E);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        r_acc;
  logic signed [ACC_W-1:0]        w_shifted;

  assign w_prod = i_a * i_b;

  // Accumulator: clear has priority so STORE can read the sum and restart in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_clear) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign w_shifted = r_acc >>> SHIFT;
  assign o_score   = DATA_WIDTH'(sat_to_width(SAT_W'(w_shifted), DATA_WIDTH));

endmodule

// File: rtl/attn_score.sv
// Sequential attention score engine: A[n][i][j] = sat((Q[i][n]·K[j][n]) >>> SHIFT),
// one MAC per cycle, results held in a register bank until the next start.
module attn_score
  import attn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 8,
  parameter int unsigned N          = 1,
  parameter int unsigned E          = 8,
  parameter int unsigned SHIFT      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DATA_WIDTH*L*N*E-1:0]      Q_in,
  input  logic [DATA_WIDTH*L*N*E-1:0]      K_in,
  output logic [DATA_WIDTH*N*L*L-1:0]      A_out,
  output logic                             done,
  output logic                             out_valid
);

  localparam int unsigned QK_W = DATA_WIDTH * L * N * E;
  localparam int unsigned A_W  = DATA_WIDTH * N * L * L;

  state_t                r_state;
  state_t                w_next;
  logic [QK_W-1:0]       r_q;
  logic [QK_W-1:0]       r_k;
  logic [A_W-1:0]        r_a;
  int unsigned           r_e;
  int unsigned           r_i;
  int unsigned           r_j;
  int unsigned           r_n;
  logic                  r_done;
  logic                  r_out_valid;

  int unsigned           w_qidx;
  int unsigned           w_kidx;
  int unsigned           w_aidx;
  logic                  w_last;
  logic                  w_clear;
  logic                  w_mac_en;
  logic [DATA_WIDTH-1:0] w_q_elem;
  logic [DATA_WIDTH-1:0] w_k_elem;
  logic [DATA_WIDTH-1:0] w_score;

  assign w_qidx   = (r_i * N + r_n) * E + r_e;
  assign w_kidx   = (r_j * N + r_n) * E + r_e;
  assign w_aidx   = (r_n * L + r_i) * L + r_j;
  assign w_q_elem = r_q[w_qidx*DATA_WIDTH +: DATA_WIDTH];
  assign w_k_elem = r_k[w_kidx*DATA_WIDTH +: DATA_WIDTH];
  assign w_last   = (r_j == L - 32'd1) && (r_i == L - 32'd1) && (r_n == N - 32'd1);
  assign w_clear  = (r_state == ST_LOAD) || (r_state == ST_STORE);
  assign w_mac_en = (r_state == ST_MAC);

  score_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .E          (E),
    .SHIFT      (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_mac_en),
    .i_a     (w_q_elem),
    .i_b     (w_k_elem),
    .o_score (w_score)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: w_next = ST_MAC;
      ST_MAC: begin
        if (r_e == E - 32'd1) begin
          w_next = ST_STORE;
        end else begin
          w_next = ST_MAC;
        end
      end
      ST_STORE: begin
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_MAC;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand capture, loop counters, score bank and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= {QK_W{1'b0}};
      r_k         <= {QK_W{1'b0}};
      r_a         <= {A_W{1'b0}};
      r_e         <= 32'd0;
      r_i         <= 32'd0;
      r_j         <= 32'd0;
      r_n         <= 32'd0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          // Clearing here makes out_valid low throughout the LOAD cycle.
          if (start) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        ST_LOAD: begin
          r_q <= Q_in;
          r_k <= K_in;
          r_e <= 32'd0;
          r_i <= 32'd0;
          r_j <= 32'd0;
          r_n <= 32'd0;
        end
        ST_MAC: begin
          r_e <= (r_e == E - 32'd1) ? 32'd0 : r_e + 32'd1;
        end
        ST_STORE: begin
          r_a[w_aidx*DATA_WIDTH +: DATA_WIDTH] <= w_score;
          r_e <= 32'd0;
          if (r_j == L - 32'd1) begin
            r_j <= 32'd0;
            if (r_i == L - 32'd1) begin
              r_i <= 32'd0;
              r_n <= (r_n == N - 32'd1) ? 32'd0 : r_n + 32'd1;
            end else begin
              r_i <= r_i + 32'd1;
            end
          end else begin
            r_j <= r_j + 32'd1;
          end
        end
        ST_DONE: r_out_valid <= 1'b1;
        default: r_out_valid <= r_out_valid;
      endcase
    end
  end

  assign A_out     = r_a;
  assign done      = r_done;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_attn_score.sv
// Scoreboard bench for attn_score: stimulus pushes hand-computed score banks and
// done cycles; a negedge monitor pops and compares on every done pulse.
module tb_attn_score;

  localparam int unsigned DW    = 16;
  localparam int unsigned L     = 8;
  localparam int unsigned N     = 1;
  localparam int unsigned E     = 8;
  localparam int unsigned SHIFT = 2;
  localparam int unsigned QW    = DW * L * N * E;
  localparam int unsigned AW    = DW * N * L * L;
  localparam int unsigned NS    = N * L * L;
  localparam int          LAT   = 2 + N * L * L * (E + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [QW-1:0] q_in;
  logic [QW-1:0] k_in;
  logic [AW-1:0] a_out;
  logic          done;
  logic          out_valid;

  attn_score #(
    .DATA_WIDTH (DW),
    .L          (L),
    .N          (N),
    .E          (E),
    .SHIFT      (SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Q_in      (q_in),
    .K_in      (k_in),
    .A_out     (a_out),
    .done      (done),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [AW-1:0] exp_a_q[$];
  int            exp_cyc_q[$];
  logic [AW-1:0] exp_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_a_q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        logic [AW-1:0] ea;
        int            ec;
        ea = exp_a_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("latency", 64'(cyc), 64'(ec));
        check("out_valid_at_done", {63'd0, out_valid}, 64'd1);
        for (int s = 0; s < NS; s++)
          check($sformatf("A[%0d]", s), 64'(a_out[s*DW +: DW]), 64'(ea[s*DW +: DW]));
      end
    end
  end

  task automatic set_q(input int l, input int n, input int e, input logic [DW-1:0] v);
    q_in[((l * N + n) * E + e) * DW +: DW] = v;
  endtask

  task automatic set_k(input int l, input int n, input int e, input logic [DW-1:0] v);
    k_in[((l * N + n) * E + e) * DW +: DW] = v;
  endtask

  task automatic set_exp(input int n, input int i, input int j, input logic [DW-1:0] v);
    exp_v[((n * L + i) * L + j) * DW +: DW] = v;
  endtask

  task automatic fill_qk(input logic [DW-1:0] qv, input logic [DW-1:0] kv);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        for (int e = 0; e < E; e++) begin
          set_q(l, n, e, qv);
          set_k(l, n, e, kv);
        end
  endtask

  task automatic fill_exp(input logic [DW-1:0] v);
    for (int n = 0; n < N; n++)
      for (int i = 0; i < L; i++)
        for (int j = 0; j < L; j++) set_exp(n, i, j, v);
  endtask

  // Issue start, queue the expectation, optionally disturb inputs, wait for done.
  task automatic run_and_wait(input string tag, input bit disturb);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_valid_low_in_load"}, {63'd0, out_valid}, 64'd0);
    exp_a_q.push_back(exp_v);
    exp_cyc_q.push_back(cyc + LAT);
    for (int t = 0; t < LAT + 20 && exp_a_q.size() != 0; t++) begin
      if (disturb && t < 40) begin
        if (t == 2) fill_qk(16'h7FFF, 16'h8000);
        start = (t % 2 == 0);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (exp_a_q.size() != 0) begin
      check({tag, "_timeout"}, 64'(exp_a_q.size()), 64'd0);
      exp_a_q.delete();
      exp_cyc_q.delete();
    end
    repeat (5) @(negedge clk);
    check({tag, "_valid_held"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_a_held"}, {63'd0, (a_out === exp_v)}, 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    q_in  = '0;
    k_in  = '0;
    exp_v = '0;
    repeat (3) @(negedge clk);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_a_zero", {63'd0, (a_out === '0)}, 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All ones: 8*1 >>> 2 = 2.
    fill_qk(16'h0001, 16'h0001);
    fill_exp(16'd2);
    run_and_wait("ones", 1'b0);

    // Row pattern: A[i][j] = (8*i*j) >>> 2 = 2*i*j.
    for (int l = 0; l < L; l++)
      for (int e = 0; e < E; e++) begin
        set_q(l, 0, e, 16'(l));
        set_k(l, 0, e, 16'(l));
      end
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) set_exp(0, i, j, 16'(2 * i * j));
    run_and_wait("rows", 1'b0);

    fill_qk(16'h7FFF, 16'h7FFF);
    fill_exp(16'h7FFF);
    run_and_wait("sat_pos", 1'b0);

    fill_qk(16'h7FFF, 16'h8000);
    fill_exp(16'h8000);
    run_and_wait("sat_neg", 1'b0);

    // -3*5*8 = -120 >>> 2 = -30.
    fill_qk(16'hFFFD, 16'h0005);
    fill_exp(16'hFFE2);
    run_and_wait("mixed", 1'b0);

    // Arithmetic shift floors: 3>>>2 = 0, -3>>>2 = -1.
    fill_qk(16'h0000, 16'h0000);
    for (int l = 0; l < L; l++) begin
      set_q(l, 0, 0, (l % 2 == 1) ? 16'hFFFF : 16'h0001);
      set_k(l, 0, 0, 16'h0003);
    end
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) set_exp(0, i, j, (i % 2 == 1) ? 16'hFFFF : 16'h0000);
    run_and_wait("floor", 1'b0);

    // Reset 100 cycles into a run: no done, cleared outputs.
    fill_qk(16'h0001, 16'h0001);
    begin
      int s0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      s0 = cyc;
      while (cyc < s0 + 100) @(negedge clk);
      check("pre_abort_busy", {63'd0, (a_out === '0)}, 64'd0);
      rst = 1'b1;
      #1;
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_valid", {63'd0, out_valid}, 64'd0);
      check("abort_a_zero", {63'd0, (a_out === '0)}, 64'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (LAT) @(negedge clk);
      check("abort_still_idle_valid", {63'd0, out_valid}, 64'd0);
    end
    for (int l = 0; l < L; l++)
      for (int e = 0; e < E; e++) begin
        set_q(l, 0, e, 16'(l));
        set_k(l, 0, e, 16'(l));
      end
    for (int i = 0; i < L; i++)
      for (int j = 0; j < L; j++) set_exp(0, i, j, 16'(2 * i * j));
    run_and_wait("restart", 1'b0);

    // Start pulses during MAC and Q/K changes after LOAD must not matter.
    fill_qk(16'h0001, 16'h0001);
    fill_exp(16'd2);
    run_and_wait("disturb", 1'b1);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/attn_score.md
ATTN_SCORE -- requirements
Module: attn_score

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed element width of Q/K/score.
REQ-002 SHALL have parameter L, default 8, sequence length.
REQ-003 SHALL have parameter N, default 1, batch size.
REQ-004 SHALL have parameter E, default 8, embedding dimension.
REQ-005 SHALL have parameter SHIFT, default 2, arithmetic right shift applied to each dot product (scaling).
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  begin one score computation when idle.
REQ-009 SHALL have port Q_in  input  DATA_WIDTH*L*N*E  Q, layout (l,n,e), element at index (l*N*E + n*E + e).
REQ-010 SHALL have port K_in  input  DATA_WIDTH*L*N*E  K, same layout as Q_in.
REQ-011 SHALL have port A_out  output  DATA_WIDTH*N*L*L  scores, layout (n,i,j), element at index (n*L*L + i*L + j).
REQ-012 SHALL have port done  output  1  one-cycle pulse at completion.
REQ-013 SHALL have port out_valid  output  1  A_out holds a complete result.

Function
REQ-014 SHALL compute A[n][i][j] = sat(( sum over e of Q[i][n][e]*K[j][n][e] ) >>> SHIFT), all operands signed two's complement.
REQ-015 SHALL use a full-precision accumulator of 2*DATA_WIDTH+clog2(E) bits; no intermediate truncation.
REQ-016 SHALL saturate the shifted sum to signed DATA_WIDTH range: max 2^(DW-1)-1, min -2^(DW-1).
REQ-017 SHALL implement FSM states IDLE, LOAD, MAC, STORE, DONE.
REQ-018 IDLE -> LOAD on start=1; LOAD captures Q_in and K_in into internal registers in 1 cycle, clears counters and accumulator, then -> MAC.
REQ-019 MAC SHALL perform exactly one multiply-accumulate per cycle for E cycles, counter e 0..E-1, then -> STORE.
REQ-020 STORE SHALL write the shift/saturated score into A register slot (n,i,j), clear accumulator, advance j, then i on j wrap, then n on i wrap; -> MAC if more scores remain, else -> DONE.
REQ-021 DONE SHALL assert done for exactly one cycle, set out_valid=1, and -> IDLE.
REQ-022 Latency from start sampled high to done high SHALL be 2 + N*L*L*(E+1) cycles (578 with defaults).
REQ-023 start SHALL be ignored in every state except IDLE; Q_in/K_in changes after LOAD SHALL not affect the result.
REQ-024 out_valid SHALL remain 1 and A_out stable from DONE until the next accepted start, at which point out_valid clears in the LOAD cycle.
REQ-025 A_out SHALL be driven only from registers; partially computed slots are not guaranteed until out_valid=1.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, done=0, out_valid=0, A_out=0, all counters and accumulator 0.
REQ-027 rst asserted mid-computation SHALL abort it with no done pulse; next start after rst release computes from scratch.

Structure
REQ-028 SHALL place the state enum type and the saturate-to-DATA_WIDTH function in shared package attn_pkg.
REQ-029 SHALL instantiate one sub-module score_mac: signed multiply, accumulate, clear, and shift/saturate output for one score.

Verification
REQ-030 All Q=1.0 (16'h0001), all K=16'h0001, defaults -> done at cycle 578, every A = 8>>>2 = 2, out_valid=1.
REQ-031 Q row i = i, K row j = j (all e) -> A[i][j] = (8*i*j)>>>2 = 2*i*j; A[7][7]=98.
REQ-032 Q=16'h7FFF, K=16'h7FFF everywhere -> all A saturate to 16'h7FFF; Q=16'h7FFF, K=16'h8000 -> all A = 16'h8000.
REQ-033 Q mixed signs: Q[0][0][e]=-3, K[0][0][e]=5 -> A[0][0] = -120>>>2 = -30 (16'hFFE2).
REQ-034 Assert rst at cycle 100 of a run -> done never pulses, out_valid=0, A_out=0; restart -> correct result at cycle 578 after new start.
REQ-035 Pulse start repeatedly during MAC and change Q_in after LOAD -> single done pulse, result matches originally loaded Q/K.
